// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the iterative M-extension unit.
// Holds the funct3 operation codes, the decoder's funct7 value for the
// M-extension, the FSM state encoding and operand-signedness helpers.
package ex_muldiv_pkg;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct7 that selects the M-extension in the OP major opcode
  localparam logic [6:0] INSTR_AL_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic rs1_signed(input logic [2:0] op);
    case (op)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: rs1_signed = 1'b1;
      default:                                   rs1_signed = 1'b0;
    endcase
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM
  function automatic logic rs2_signed(input logic [2:0] op);
    case (op)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: rs2_signed = 1'b1;
      default:                         rs2_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_divstep.sv
// ex_muldiv_divstep: one combinational restoring-division step.
// Ports:
//   rem_i          partial remainder (XLEN+1 bits)
//   dividend_bit_i next dividend bit shifted in at the bottom
//   divisor_i      divisor magnitude
//   rem_o          new partial remainder
//   quot_bit_o     quotient bit produced by this step
module ex_muldiv_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            quot_bit_o
);

  logic [XLEN:0] shifted_d;
  logic [XLEN:0] diff_d;

  // Trial subtract; rem_i[XLEN] set means the shifted value exceeds 2^(XLEN+1)
  // and is therefore above any divisor. The modular difference is exact
  // whenever the subtraction is taken because the result is below the divisor.
  always_comb begin
    shifted_d  = {rem_i[XLEN-1:0], dividend_bit_i};
    diff_d     = shifted_d - {1'b0, divisor_i};
    quot_bit_o = rem_i[XLEN] | (shifted_d >= {1'b0, divisor_i});
    if (quot_bit_o) begin
      rem_o = diff_d;
    end else begin
      rem_o = shifted_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M/RV64M multiply/divide unit, one bit per cycle.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flush_i                      kill in-flight operation
//   in_valid_i / in_ready_o      operand handshake (ready only in IDLE)
//   op_i, rs1_rdata_i, rs2_rdata_i, rd_idx_i   operation, operands, dest tag
//   out_valid_o / out_ready_i    result handshake
//   out_rd_idx_o, out_result_o   registered tag and result
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2:0]               op_i,
  input  logic [XLEN-1:0]          rs1_rdata_i,
  input  logic [XLEN-1:0]          rs2_rdata_i,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [REG_IDX_WIDTH-1:0] out_rd_idx_o,
  output logic [XLEN-1:0]          out_result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int W2    = 2 * XLEN;
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [2:0]               op_q;
  logic                     neg_res_q;
  logic                     neg_rem_q;
  logic [XLEN-1:0]          a_q;       // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0]          b_q;       // divisor magnitude
  logic [W2-1:0]            acc_q;     // {partial high, remaining multiplier bits}
  logic [XLEN:0]            rem_q;
  logic                     out_valid_q;
  logic [XLEN-1:0]          out_result_q;
  logic [REG_IDX_WIDTH-1:0] out_rd_q;

  logic            neg1_d, neg2_d;
  logic [XLEN-1:0] mag1_d, mag2_d;
  logic            div_zero_d, ovf_d;
  logic [XLEN-1:0] special_res_d;
  logic [XLEN:0]   mul_sum_d;
  logic [W2-1:0]   acc_d, prod_d;
  logic [XLEN:0]   rem_d;
  logic            qbit_d;
  logic [XLEN-1:0] quo_d, quo_fix_d, rem_fix_d;
  logic [XLEN-1:0] result_d;

  assign in_ready_o   = (state_q == ST_IDLE);
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_rd_idx_o = out_rd_q;

  // Operand magnitudes, sign flags and the special cases resolved at accept
  always_comb begin
    neg1_d     = rs1_signed(op_i) & rs1_rdata_i[XLEN-1];
    neg2_d     = rs2_signed(op_i) & rs2_rdata_i[XLEN-1];
    mag1_d     = neg1_d ? (~rs1_rdata_i + XLEN'(1)) : rs1_rdata_i;
    mag2_d     = neg2_d ? (~rs2_rdata_i + XLEN'(1)) : rs2_rdata_i;
    div_zero_d = op_i[2] & (rs2_rdata_i == ZERO);
    ovf_d      = op_i[2] & ~op_i[0] & (rs1_rdata_i == MIN) & (rs2_rdata_i == ONES);
    if (div_zero_d) begin
      special_res_d = op_i[1] ? rs1_rdata_i : ONES;
    end else if (ovf_d) begin
      special_res_d = op_i[1] ? ZERO : rs1_rdata_i;
    end else begin
      special_res_d = ZERO;
    end
  end

  ex_muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_i          (rem_q),
    .dividend_bit_i (a_q[XLEN-1]),
    .divisor_i      (b_q),
    .rem_o          (rem_d),
    .quot_bit_o     (qbit_d)
  );

  // One iteration of shift-add multiply, plus final sign correction/selection
  always_comb begin
    mul_sum_d = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {1'b0, ZERO});
    acc_d     = {mul_sum_d, acc_q[XLEN-1:1]};
    prod_d    = neg_res_q ? (~acc_d + W2'(1)) : acc_d;
    quo_d     = {a_q[XLEN-2:0], qbit_d};
    quo_fix_d = neg_res_q ? (~quo_d + XLEN'(1)) : quo_d;
    rem_fix_d = neg_rem_q ? (~rem_d[XLEN-1:0] + XLEN'(1)) : rem_d[XLEN-1:0];
    if (op_q[2]) begin
      result_d = op_q[1] ? rem_fix_d : quo_fix_d;
    end else if (op_q[1:0] == 2'b00) begin
      result_d = prod_d[XLEN-1:0];
    end else begin
      result_d = prod_d[W2-1:XLEN];
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      op_q         <= 3'b000;
      neg_res_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      a_q          <= ZERO;
      b_q          <= ZERO;
      acc_q        <= {W2{1'b0}};
      rem_q        <= {(XLEN+1){1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= ZERO;
      out_rd_q     <= {REG_IDX_WIDTH{1'b0}};
    end else if (flush_i) begin
      // Flush wins over accept and over the output handshake
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            op_q      <= op_i;
            out_rd_q  <= rd_idx_i;
            neg_res_q <= neg1_d ^ neg2_d;
            neg_rem_q <= neg1_d;
            a_q       <= mag1_d;
            b_q       <= mag2_d;
            acc_q     <= {ZERO, mag2_d};
            rem_q     <= {(XLEN+1){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            if (div_zero_d || ovf_d) begin
              out_result_q <= special_res_d;
              out_valid_q  <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (op_q[2]) begin
            a_q   <= quo_d;
            rem_q <= rem_d;
          end else begin
            acc_q <= acc_d;
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            out_result_q <= result_d;
            out_valid_q  <= 1'b1;
            cnt_q        <= {CNT_W{1'b0}};
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative, parametrised multiply/divide execute unit implementing the RV32M/RV64M integer operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the EX stage: the EX stage hands over operands with a valid/ready handshake, stalls while the unit iterates one bit per cycle, and takes the result plus destination tag for writeback. A pipeline flush from the branch-resolution logic kills any operation in flight.

## Interface
- XLEN, default 32: operand and result width; legal values 32 and 64.
- REG_IDX_WIDTH, default 5: width of the destination register tag.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill the in-flight operation. Synchronous, one cycle.
- in_valid_i  in  1  operands and op are valid.
- in_ready_o  out  1  unit can accept; high only in IDLE.
- op_i  in  3  funct3 of the M-extension instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_rdata_i  in  XLEN  operand 1 (multiplicand / dividend).
- rs2_rdata_i  in  XLEN  operand 2 (multiplier / divisor).
- rd_idx_i  in  REG_IDX_WIDTH  destination tag, returned unchanged.
- out_valid_o  out  1  result valid; held until accepted.
- out_ready_i  in  1  consumer takes result.
- out_rd_idx_o  out  REG_IDX_WIDTH  registered destination tag.
- out_result_o  out  XLEN  result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready_o=1. If in_valid_i & ~flush_i, latch op, tag, operand magnitudes and sign flags.
- After latching, a special case goes to DONE. Otherwise the unit goes to CALC with cnt=0.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- Negative signed operands are stored as two's-complement magnitudes.
- Multiply: unsigned shift-add over a 2*XLEN accumulator, one multiplier bit per CALC cycle. The product is negated at the end if the operand signs differ.
  - MUL returns product[XLEN-1:0].
  - MULH* return product[2*XLEN-1:XLEN].
- Divide: restoring division on magnitudes, one quotient bit per CALC cycle, with an (XLEN+1)-bit partial remainder.
  - The quotient is negated if sign1^sign2.
  - The remainder takes the sign of the dividend.
- Special cases resolve at accept with no CALC:
  - Divide by zero: DIV/DIVU return all ones. REM/REMU return rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = -1): DIV returns rs1. REM returns 0.
- CALC: cnt increments every cycle. When cnt==XLEN-1, the final sign correction is applied and the result is registered into out_result_o. The state then moves to DONE.
- DONE: out_valid_o=1, with result and tag stable. out_valid_o & out_ready_i leads to IDLE.
- flush_i in any state leads to IDLE on the next edge with out_valid_o=0, and the result is discarded.
  - flush_i takes priority over an accept in the same cycle; the operation is not accepted.
  - flush_i takes priority over an output handshake in the same cycle; the result is dropped.
- Reset values: state IDLE, cnt 0, out_valid_o 0, out_result_o 0, out_rd_idx_o 0. in_ready_o is therefore 1 out of reset.

## Timing
- Accept edge = cycle 0.
- Normal op: CALC occupies cycles 1..XLEN, and out_valid_o rises in cycle XLEN+1. For XLEN=32 that is cycle 33.
- Special case: out_valid_o rises in cycle 1.
- Throughput: a new op can be accepted the cycle after the output handshake. There is no accept in the same cycle as the handshake.
- out_ready_i may be low indefinitely; DONE holds.
- Reset asserted mid-CALC clears all state immediately, without waiting for an edge.

## Structure
- Add to defines.v: M-extension funct3 codes (`MUL..`REMU), `INSTR_AL funct7 value 7'b0000001 for the decoder, and state encodings.
- Sub-module ex_muldiv_divstep: a combinational single restoring step. It takes the partial remainder, the next dividend bit and the divisor, and outputs the new remainder and quotient bit.
- The top level holds the FSM, counter, accumulators, sign handling and handshake.

## Test plan
- MUL: 7 × -3, XLEN=32 → 0xFFFFFFEB at cycle 33.
- MULH: 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU: -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- MULHU: same operands → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both at cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same operands → 0.
- Assert flush_i in CALC cycle 10: out_valid_o never rises and in_ready_o=1 next cycle. A following MUL 3×4 returns 12 with the correct tag.
- Hold out_ready_i low for 5 cycles in DONE: result and tag stay stable and in_ready_o=0. Assert async rst mid-CALC: out_valid_o=0 and in_ready_o=1 immediately.
